// File: rtl/mips_pkg.sv
// Shared defaults and word/address types for the simplified MIPS datapath.
package mips_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 2;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] data_word_t;

endpackage

// File: rtl/reg_file_param_if.sv
// Decode-stage <-> register file bus: two read ports, one write port, reserve.
interface reg_file_param_if
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [ADDR_W-1:0]   RR1;
  logic [ADDR_W-1:0]   RR2;
  logic [DATA_W-1:0]   RD1;
  logic [DATA_W-1:0]   RD2;
  logic                Ready1;
  logic                Ready2;
  logic [ADDR_W-1:0]   WR;
  logic [DATA_W-1:0]   WD;
  logic                RegWrite;
  logic                Reserve;
  logic [ADDR_W-1:0]   RsvReg;
  logic [NUM_REGS-1:0] Busy;

  // Decode stage side
  modport master (
    output RR1, RR2, WR, WD, RegWrite, Reserve, RsvReg,
    input  RD1, RD2, Ready1, Ready2, Busy
  );

  // Register file side
  modport slave (
    input  RR1, RR2, WR, WD, RegWrite, Reserve, RsvReg,
    output RD1, RD2, Ready1, Ready2, Busy
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits: set on reserve, cleared on write-back, reserve wins.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       Reserve,
  input  logic [ADDR_W-1:0]          RsvReg,
  input  logic                       RegWrite,
  input  logic [ADDR_W-1:0]          WR,
  output logic [(1 << ADDR_W)-1:0]   Busy
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;

  logic [NUM_REGS-1:0] busy_next;

  // Clear on write-back first so a same-cycle reserve overrides it; bit 0 pinned low
  always_comb begin
    busy_next = Busy;
    if (RegWrite && (WR != '0)) begin
      busy_next[WR] = 1'b0;
    end
    if (Reserve && (RsvReg != '0)) begin
      busy_next[RsvReg] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clock) begin
    if (reset) begin
      Busy <= '0;
    end else begin
      Busy <= busy_next;
    end
  end

endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: r0 hard-wired to zero, busy scoreboard, optional bypass.
module reg_file_param
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input logic             clock,
  input logic             reset,
  reg_file_param_if.slave bus
);

  localparam int unsigned NUM_REGS  = 1 << ADDR_W;
  localparam int unsigned NUM_PORTS = 2;

  logic [DATA_W-1:0]   regs    [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic                wr_en;
  logic [ADDR_W-1:0]   rd_addr [NUM_PORTS];
  logic [DATA_W-1:0]   rd_data [NUM_PORTS];
  logic                rd_rdy  [NUM_PORTS];

  assign wr_en = bus.RegWrite && (bus.WR != '0);

  // Storage: register 0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[bus.WR] <= bus.WD;
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .Reserve  (bus.Reserve),
    .RsvReg   (bus.RsvReg),
    .RegWrite (bus.RegWrite),
    .WR       (bus.WR),
    .Busy     (busy)
  );

  assign bus.Busy   = busy;
  assign rd_addr[0] = bus.RR1;
  assign rd_addr[1] = bus.RR2;

  // Per-port read mux: r0 -> zero, then same-cycle forward, then storage
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic addr_zero;
    logic fwd_hit;

    assign addr_zero  = (rd_addr[p] == '0);
    assign fwd_hit    = BYPASS && wr_en && (bus.WR == rd_addr[p]);
    assign rd_data[p] = addr_zero ? '0 : (fwd_hit ? bus.WD : regs[rd_addr[p]]);
    assign rd_rdy[p]  = addr_zero | fwd_hit | ~busy[rd_addr[p]];
  end

  assign bus.RD1    = rd_data[0];
  assign bus.RD2    = rd_data[1];
  assign bus.Ready1 = rd_rdy[0];
  assign bus.Ready2 = rd_rdy[1];

endmodule
